sid_filter_seq: RTL and testbench
=================================

Name: sid_filter_seq

Overview:
- Sequencer and state store for the time-multiplexed sid_filter datapath.
- On each SID-cycle tick it runs the filter through stages 1..7 once per emulated chip.
- It supplies each chip's stored integrator state (vlp/vbp/vhp) and writes back the updated state the filter returns.
- It collects per-chip audio samples and publishes them together with a valid pulse.

Parameters:
- NUM_SIDS, 2, number of emulated chips sharing one filter datapath (1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle SID-cycle tick; begins a sequence when idle
- clear  in  1  synchronous zeroing of all stored filter state (e.g. model change)
- stage  out  3  filter stage number; 0 when idle or in writeback
- sid_idx  out  $clog2(NUM_SIDS) (min 1)  chip being processed; muxes regs/voices upstream
- state_o  out  sid::filter_v_t  stored state of chip sid_idx, driven to the filter state input
- state_i  in  sid::filter_v_t  updated state from the filter
- audio_i  in  sid::s24_t  filter audio output
- audio_o  out  NUM_SIDS x sid::s24_t  published samples, one per chip
- audio_valid  out  1  one-cycle pulse when audio_o is updated
- busy  out  1  sequence in progress
- overrun  out  1  sticky; start arrived while busy

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM enters IDLE; stage=0, sid_idx=0, busy=0, audio_valid=0, overrun=0.
  - All stored states are zero; all audio_o are zero.
- FSM states: IDLE, RUN, WB.
- IDLE:
  - start=1 and clear=0 leads to RUN with stage=1, sid_idx=0, busy=1 on the next cycle.
- RUN:
  - stage increments by 1 each cycle, from 1 to 7.
  - After stage 7 the FSM enters WB with stage=0.
- WB (one cycle per chip):
  - At the end of the WB cycle, state_i is written to storage[sid_idx] and audio_i to pending[sid_idx].
  - If sid_idx < NUM_SIDS-1: sid_idx increments and the FSM returns to RUN with stage=1.
  - Otherwise the FSM goes to IDLE, all pending samples are copied to audio_o, and audio_valid=1 for exactly one cycle.
- Per-chip timing: 8 cycles.
  - start sampled at edge 0.
  - busy high for cycles 1..8*NUM_SIDS.
  - audio_valid high in cycle 8*NUM_SIDS+1.
- state_o:
  - Equals storage[sid_idx], registered or combinational from the register file.
  - Must be stable for every cycle with stage 1..7 and WB of that chip.
- Filter-side relationships:
  - The filter consumes state_o during stages 3..5.
  - The filter's own vbp/vlp/vhp/audio outputs are all valid during WB, which is why writeback occurs there.
- start while busy (including the final WB cycle):
  - Ignored; overrun is set to 1.
  - overrun clears only on reset.
- start in the same cycle audio_valid=1: accepted, since the FSM is IDLE.
- clear (highest priority):
  - All storage and pending are zeroed next cycle; audio_o is unchanged.
  - Any sequence in progress aborts to IDLE; no audio_valid; stage=0, sid_idx=0.
  - clear and start together: start is dropped and overrun is not set.
- Width rules:
  - Storage is NUM_SIDS entries of 72 bits (3 x s24).
  - No arithmetic on state; values pass bit-exact.
- sid_idx never exceeds NUM_SIDS-1. With NUM_SIDS=1 the WB transition always goes to IDLE.

Decomposition:
- Add to package sid:
  - filter_seq_state_t (enum IDLE/RUN/WB).
  - STAGE_FIRST=1 and STAGE_LAST=7 constants.
  - s24_t and filter_v_t are reused.
- Sub-module sid_filter_state_ram:
  - NUM_SIDS x filter_v_t register file.
  - One asynchronous read port and one write port with synchronous clear.
  - Asynchronous reset to zero.
  - Kept separate so it can map to LUT RAM later.

Test Plan:
- Reset then single start (NUM_SIDS=2) -> stage sequence is 1..7,0 with sid_idx=0, then 1..7,0 with sid_idx=1; busy high cycles 1..16; audio_valid only in cycle 17.
- Model filter returns state_i = {vlp=idx+1, vbp=0x000100*(idx+1), vhp=-1} and audio_i=0x123400+idx -> second sequence shows state_o equal to those values per chip; audio_o[0]=0x123400, audio_o[1]=0x123401.
- start pulse at cycle 5 of a running sequence -> ignored, overrun=1 and stays 1; audio_valid timing unchanged (cycle 17).
- clear asserted in cycle 10 (chip 1, stage 2) -> IDLE next cycle, no audio_valid, audio_o retains prior values; next sequence presents state_o=0 for both chips.
- start and clear in the same idle cycle -> stays IDLE, overrun=0, storage zero.
- Assert rst_n low mid-stage 4 without a clock edge -> stage=0, busy=0, audio_o=0 immediately; start in the cycle audio_valid=1 -> new sequence begins next cycle.

Source files
------------

// File: rtl/sid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sid (package)
//  Brief    : Shared types and constants for the sid filter datapath and
//             its sequencer / state store.
//  Revision : 1.0 - initial release
// ============================================================================
package sid;

   // Signed 24-bit sample / integrator word
   typedef logic signed [23:0] s24_t;

   // Filter integrator state, 72 bits, passed around bit-exact
   typedef struct packed {
      s24_t vlp;
      s24_t vbp;
      s24_t vhp;
   } filter_v_t;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WB   = 2'd2
   } filter_seq_state_t;

   // Filter stage range walked once per chip
   localparam logic [2:0] STAGE_FIRST = 3'd1;
   localparam logic [2:0] STAGE_LAST  = 3'd7;

   // Width of a chip index; never narrower than one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sid_filter_state_ram.sv
`default_nettype none
// ============================================================================
//  Module   : sid_filter_state_ram
//  Brief    : Per-chip filter state register file. One asynchronous read
//             port, one synchronous write port, synchronous clear of all
//             entries and asynchronous reset to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module sid_filter_state_ram
   import sid::*;
#(
   parameter int NUM_SIDS = 2,
   parameter int IDX_W    = 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_waddr,
   input  filter_v_t        i_wdata,
   input  logic [IDX_W-1:0] i_raddr,
   output filter_v_t        o_rdata
);

   filter_v_t r_mem [NUM_SIDS];

   // Storage: clear wins over a simultaneous write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SIDS; i++) r_mem[i] <= '0;
      end else if (i_clear) begin
         for (int i = 0; i < NUM_SIDS; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Asynchronous read so the addressed state is visible in the same cycle
   always_comb begin
      o_rdata = r_mem[i_raddr];
   end

endmodule
`default_nettype wire

// File: rtl/sid_filter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sid_filter_seq
//  Brief    : Sequencer for the time-multiplexed sid filter. Per SID-cycle
//             tick it walks stages 1..7 plus a writeback cycle for each
//             emulated chip, feeds the stored integrator state, writes back
//             the updated state and publishes per-chip audio samples.
//  Revision : 1.0 - initial release
// ============================================================================
module sid_filter_seq
   import sid::*;
#(
   parameter  int NUM_SIDS = 2,
   localparam int IDX_W    = idx_width(NUM_SIDS)
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  clear,
   output logic [2:0]            stage,
   output logic [IDX_W-1:0]      sid_idx,
   output filter_v_t             state_o,
   input  filter_v_t             state_i,
   input  s24_t                  audio_i,
   output s24_t [NUM_SIDS-1:0]   audio_o,
   output logic                  audio_valid,
   output logic                  busy,
   output logic                  overrun
);

   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_SIDS - 1);

   filter_seq_state_t    r_state;
   filter_seq_state_t    w_state_nxt;
   logic [2:0]           r_stage;
   logic [2:0]           w_stage_nxt;
   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic                 w_wb_we;
   logic                 w_publish;
   logic                 w_overrun_set;
   logic                 r_audio_valid;
   logic                 r_overrun;
   s24_t                 r_pending [NUM_SIDS];
   s24_t [NUM_SIDS-1:0]  r_audio;

   // FSM state, stage counter and chip index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_stage <= 3'd0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_stage <= w_stage_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next-state logic; clear aborts everything and drops a coincident start
   always_comb begin
      w_state_nxt = r_state;
      w_stage_nxt = r_stage;
      w_idx_nxt   = r_idx;
      w_wb_we     = 1'b0;
      w_publish   = 1'b0;
      if (clear) begin
         w_state_nxt = IDLE;
         w_stage_nxt = 3'd0;
         w_idx_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  w_state_nxt = RUN;
                  w_stage_nxt = STAGE_FIRST;
                  w_idx_nxt   = '0;
               end
            end
            RUN: begin
               if (r_stage == STAGE_LAST) begin
                  w_state_nxt = WB;
                  w_stage_nxt = 3'd0;
               end else begin
                  w_stage_nxt = r_stage + 3'd1;
               end
            end
            WB: begin
               w_wb_we = 1'b1;
               if (r_idx == c_LAST_IDX) begin
                  w_state_nxt = IDLE;
                  w_stage_nxt = 3'd0;
                  w_idx_nxt   = '0;
                  w_publish   = 1'b1;
               end else begin
                  w_state_nxt = RUN;
                  w_stage_nxt = STAGE_FIRST;
                  w_idx_nxt   = r_idx + 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_stage_nxt = 3'd0;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   // A start that cannot be honoured because a sequence is running
   always_comb begin
      w_overrun_set = start && !clear && (r_state != IDLE);
   end

   // Sticky overrun flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (w_overrun_set) begin
         r_overrun <= 1'b1;
      end
   end

   // Pending samples collected at each chip's writeback cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SIDS; i++) r_pending[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_SIDS; i++) r_pending[i] <= '0;
      end else if (w_wb_we) begin
         r_pending[r_idx] <= audio_i;
      end
   end

   // Publish: the last chip's sample bypasses pending since it lands on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_audio       <= '0;
         r_audio_valid <= 1'b0;
      end else begin
         r_audio_valid <= w_publish;
         if (w_publish) begin
            for (int i = 0; i < NUM_SIDS; i++) begin
               r_audio[i] <= (IDX_W'(i) == r_idx) ? audio_i : r_pending[i];
            end
         end
      end
   end

   sid_filter_state_ram #(
      .NUM_SIDS (NUM_SIDS),
      .IDX_W    (IDX_W)
   ) u_state_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (clear),
      .i_we    (w_wb_we),
      .i_waddr (r_idx),
      .i_wdata (state_i),
      .i_raddr (r_idx),
      .o_rdata (state_o)
   );

   assign stage       = r_stage;
   assign sid_idx     = r_idx;
   assign audio_o     = r_audio;
   assign audio_valid = r_audio_valid;
   assign busy        = (r_state != IDLE);
   assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sid_filter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sid_filter_seq
//  Brief    : Self-checking bench for sid_filter_seq with a scoreboard fed
//             by the stimulus and drained by a negedge monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sid_filter_seq;
   import sid::*;

   localparam int NS = 2;

   typedef struct {
      int         cyc;
      int         stage;
      int         idx;
   } trace_t;

   typedef struct {
      int                  cyc;
      logic [NS*24-1:0]    aud;
   } aud_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              clear;
   logic [2:0]        stage;
   logic [0:0]        sid_idx;
   filter_v_t         state_o;
   filter_v_t         state_i;
   s24_t              audio_i;
   s24_t [NS-1:0]     audio_o;
   logic              audio_valid;
   logic              busy;
   logic              overrun;

   // Filter stand-in: fixed per-chip results for the sequence in flight
   filter_v_t         seq_state [NS];
   s24_t              seq_audio [NS];

   // Reference model
   filter_v_t         m_store [NS];
   s24_t              m_audio [NS];
   bit                exp_ovr;

   // Scoreboard queues
   trace_t            tr_q [$];
   filter_v_t         st_q [$];
   aud_t              av_q [$];

   int                cyc = 0;
   int                n_cmp = 0;
   int                n_err = 0;
   bit                mon_en = 1'b0;

   sid_filter_seq #(.NUM_SIDS(NS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .clear       (clear),
      .stage       (stage),
      .sid_idx     (sid_idx),
      .state_o     (state_o),
      .state_i     (state_i),
      .audio_i     (audio_i),
      .audio_o     (audio_o),
      .audio_valid (audio_valid),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign state_i = seq_state[sid_idx];
   assign audio_i = seq_audio[sid_idx];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [NS*24-1:0] pack_audio(input s24_t a [NS]);
      logic [NS*24-1:0] v;
      for (int c = 0; c < NS; c++) v[c*24 +: 24] = a[c];
      return v;
   endfunction

   // Monitor: compares every cycle against whatever the scoreboard expects now
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         trace_t e;
         filter_v_t s;
         aud_t a;
         bit exp_busy;
         bit exp_av;
         chk("overrun", overrun, exp_ovr);
         exp_busy = (tr_q.size() > 0) && (tr_q[0].cyc == cyc);
         chk("busy", busy, exp_busy);
         if (exp_busy) begin
            e = tr_q.pop_front();
            chk("stage", stage, e.stage);
            chk("sid_idx", sid_idx, e.idx);
            if (e.stage == 3) begin
               if (st_q.size() > 0) begin
                  s = st_q.pop_front();
                  chk("state_o", state_o, s);
               end else begin
                  chk("state_q_empty", 1, 0);
               end
            end
         end else begin
            chk("idle_stage", stage, 0);
            chk("idle_sid_idx", sid_idx, 0);
         end
         exp_av = (av_q.size() > 0) && (av_q[0].cyc == cyc);
         chk("audio_valid", audio_valid, exp_av);
         if (exp_av) begin
            a = av_q.pop_front();
            chk("audio_o", audio_o, a.aud);
         end
      end
   end

   task automatic flush_sb();
      tr_q.delete();
      st_q.delete();
      av_q.delete();
   endtask

   // One sequence; optional overrun pulse, clear or async reset at cycle k
   task automatic run_seq(input int ovr_at, input int clr_at, input int rst_at, input bit directed);
      int c0;
      bit ovr_pend;
      ovr_pend = 1'b0;
      for (int c = 0; c < NS; c++) begin
         if (directed) begin
            seq_state[c].vlp = 24'(c + 1);
            seq_state[c].vbp = 24'(32'h100 * (c + 1));
            seq_state[c].vhp = '1;
            seq_audio[c]     = 24'(32'h123400 + c);
         end else begin
            seq_state[c].vlp = 24'($urandom());
            seq_state[c].vbp = 24'($urandom());
            seq_state[c].vhp = 24'($urandom());
            seq_audio[c]     = 24'($urandom());
         end
      end
      c0 = cyc;
      for (int k = 1; k <= 8 * NS; k++) begin
         int s;
         s = (k - 1) % 8;
         tr_q.push_back('{cyc: c0 + k, stage: (s == 7) ? 0 : s + 1, idx: (k - 1) / 8});
      end
      for (int c = 0; c < NS; c++) st_q.push_back(m_store[c]);
      av_q.push_back('{cyc: c0 + 8 * NS + 1, aud: pack_audio(seq_audio)});
      start = 1'b1;
      for (int k = 1; k <= 8 * NS + 1; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         clear = 1'b0;
         if (ovr_pend) begin
            exp_ovr  = 1'b1;
            ovr_pend = 1'b0;
         end
         if (clr_at > 0 && k == clr_at + 1) begin
            flush_sb();
            for (int c = 0; c < NS; c++) m_store[c] = '0;
            return;
         end
         if (k == clr_at) clear = 1'b1;
         if (k == ovr_at) begin
            start    = 1'b1;
            ovr_pend = 1'b1;
         end
         if (k == rst_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk("arst_stage", stage, 0);
            chk("arst_busy", busy, 0);
            chk("arst_audio_o", audio_o, 0);
            chk("arst_overrun", overrun, 0);
            chk("arst_state_o", state_o, 0);
            flush_sb();
            for (int c = 0; c < NS; c++) begin
               m_store[c] = '0;
               m_audio[c] = '0;
            end
            exp_ovr = 1'b0;
            #3;
            rst_n = 1'b1;
            @(posedge clk); #1;
            return;
         end
      end
      for (int c = 0; c < NS; c++) begin
         m_store[c] = seq_state[c];
         m_audio[c] = seq_audio[c];
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      clear   = 1'b0;
      exp_ovr = 1'b0;
      for (int c = 0; c < NS; c++) begin
         m_store[c]   = '0;
         m_audio[c]   = '0;
         seq_state[c] = '0;
         seq_audio[c] = '0;
      end
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_stage", stage, 0);
      chk("rst_sid_idx", sid_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_audio_valid", audio_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_audio_o", audio_o, 0);
      chk("rst_state_o", state_o, 0);
      mon_en = 1'b1;

      // Directed pair: second pass presents the first pass's written state
      run_seq(0, 0, 0, 1'b1);
      idle(2);
      run_seq(5, 0, 0, 1'b1);
      idle(1);

      // Clear mid chip 1: no publish, audio_o retained, storage zeroed
      run_seq(0, 10, 0, 1'b0);
      idle(8);
      for (int c = 0; c < NS; c++) chk("clear_keeps_audio_o", audio_o[c], m_audio[c]);
      run_seq(0, 0, 0, 1'b0);
      idle(1);

      // Start during the final writeback cycle
      run_seq(8 * NS, 0, 0, 1'b0);
      idle(1);

      // Asynchronous reset during stage 4
      run_seq(0, 0, 4, 1'b0);
      idle(1);

      // start together with clear while idle
      start = 1'b1;
      clear = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      clear = 1'b0;
      chk("start_clear_busy", busy, 0);
      chk("start_clear_overrun", overrun, 0);
      idle(1);

      // Back-to-back: second start lands in the audio_valid cycle
      run_seq(0, 0, 0, 1'b0);
      run_seq(0, 0, 0, 1'b0);

      // Randomised tail
      repeat (6) begin
         idle($urandom_range(0, 3));
         run_seq(($urandom_range(0, 3) == 0) ? $urandom_range(1, 8 * NS) : 0, 0, 0, 1'b0);
      end

      idle(4);
      chk("trace_left", tr_q.size(), 0);
      chk("state_left", st_q.size(), 0);
      chk("audio_left", av_q.size(), 0);
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
